// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the MIPS core and a loader/debug port.
// Zero-cycle grant/stall, reads return one cycle after grant; loader wins ties until the core has waited MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // core requester
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  // loader requester
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_halt,
  output logic              ld_gnt,
  output logic              ld_halted,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  // memory
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             core_grant;
  logic             loader_grant;
  logic             core_rd_q;
  logic             ld_rd_q;
  mem_req_t         core_fields;
  mem_req_t         ld_fields;
  mem_req_t         sel_fields;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; a halt request dropped during DRAIN returns straight to RUN
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     state_nxt = ld_halt ? DRAIN : RUN;
      DRAIN:   state_nxt = ld_halt ? HALTED : RUN;
      HALTED:  state_nxt = ld_halt ? HALTED : RUN;
      default: state_nxt = RUN;
    endcase
  end

  // grant logic: the core is shut out from the cycle ld_halt is seen until RUN resumes
  always_comb begin
    core_grant   = 1'b0;
    loader_grant = 1'b0;
    unique case (state)
      RUN: begin
        if (ld_halt) begin
          loader_grant = ld_req;
        end else if (core_req && ld_req) begin
          core_grant   = (wait_cnt == WAIT_MAX);
          loader_grant = (wait_cnt != WAIT_MAX);
        end else begin
          core_grant   = core_req;
          loader_grant = ld_req;
        end
      end
      default: begin
        loader_grant = ld_req;
      end
    endcase
  end

  assign core_stall = core_req & ~core_grant;
  assign ld_gnt     = ld_req & loader_grant;
  assign ld_halted  = (state == HALTED);

  assign core_fields = '{we: core_we, addr: core_addr, wdata: core_wdata};
  assign ld_fields   = '{we: ld_we,   addr: ld_addr,   wdata: ld_wdata};
  assign sel_fields  = core_grant ? core_fields : ld_fields;

  assign mem_en    = core_grant | loader_grant;
  assign mem_we    = mem_en & sel_fields.we;
  assign mem_addr  = sel_fields.addr;
  assign mem_wdata = sel_fields.wdata;

  // starvation counter: counts consecutive denied core cycles, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != RUN || !core_req || core_grant) begin
      wait_cnt <= '0;
    end else if (core_stall && wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // owner tag of the read in flight; only one can be outstanding per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rd_q <= 1'b0;
      ld_rd_q   <= 1'b0;
    end else begin
      core_rd_q <= core_grant & ~core_we;
      ld_rd_q   <= loader_grant & ~ld_we;
    end
  end

  assign core_rvalid = core_rd_q;
  assign ld_rvalid   = ld_rd_q;
  assign core_rdata  = mem_rdata;
  assign ld_rdata    = mem_rdata;

  a_one_grant : assert property (@(posedge clk) disable iff (!rst)
    !(core_grant && loader_grant));
  a_one_rvalid : assert property (@(posedge clk) disable iff (!rst)
    !(core_rvalid && ld_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0, ld_halt = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic        ld_gnt, ld_halted, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_halt(ld_halt), .ld_gnt(ld_gnt), .ld_halted(ld_halted),
    .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[11:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0;
    ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_core_stall got %b exp 0", core_stall); end
    checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL rst_ld_gnt got %b exp 0", ld_gnt); end
    checks++; if ({core_rvalid, ld_rvalid, ld_halted} !== 3'b000) begin errors++; $display("FAIL rst_status got %b exp 000", {core_rvalid, ld_rvalid, ld_halted}); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({mem_en, core_stall, ld_gnt, core_rvalid, ld_rvalid, ld_halted} !== 6'b0) begin errors++; $display("FAIL post_rst_idle got %b exp 000000", {mem_en, core_stall, ld_gnt, core_rvalid, ld_rvalid, ld_halted}); end
  endtask

  task automatic test_core_read();
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL crd_mem_en got %b%b exp 10", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL crd_addr got %h exp 00000040", mem_addr); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL crd_stall got %b exp 0", core_stall); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1) begin errors++; $display("FAIL crd_rvalid got %b exp 1", core_rvalid); end
    checks++; if (core_rdata !== 32'h1234_5678) begin errors++; $display("FAIL crd_rdata got %h exp 12345678", core_rdata); end
    checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL crd_ld_rvalid got %b exp 0", ld_rvalid); end
    tick();
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL crd_rvalid_once got %b exp 0", core_rvalid); end
  endtask

  task automatic test_contention();
    logic core_turn;
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hC0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'hA0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      core_turn = (i % 5 == 4);
      checks++; if (ld_gnt !== !core_turn) begin errors++; $display("FAIL cont_ld_gnt cyc %0d got %b exp %b", i, ld_gnt, !core_turn); end
      checks++; if (core_stall !== !core_turn) begin errors++; $display("FAIL cont_stall cyc %0d got %b exp %b", i, core_stall, !core_turn); end
      checks++; if (mem_addr !== (core_turn ? 32'h10 : 32'h20) || mem_wdata !== (core_turn ? 32'hC0 : 32'hA0)) begin
        errors++; $display("FAIL cont_mux cyc %0d got %h/%h", i, mem_addr, mem_wdata); end
    end
    tick();
    idle();
  endtask

  task automatic test_halt_entry();
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL he_grant got %b exp 0", core_stall); end
    tick();
    ld_halt = 1'b1;
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h1234_5678) begin errors++; $display("FAIL he_rvalid got %b %h exp 1 12345678", core_rvalid, core_rdata); end
    checks++; if (core_stall !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL he_stall_c1 got %b%b exp 10", core_stall, mem_en); end
    checks++; if (ld_halted !== 1'b0) begin errors++; $display("FAIL he_halted_c1 got %b exp 0", ld_halted); end
    tick();
    @(negedge clk);
    checks++; if (core_stall !== 1'b1 || ld_halted !== 1'b0 || core_rvalid !== 1'b0) begin
      errors++; $display("FAIL he_drain got %b%b%b exp 100", core_stall, ld_halted, core_rvalid); end
    tick();
    @(negedge clk);
    checks++; if (ld_halted !== 1'b1 || core_stall !== 1'b1) begin errors++; $display("FAIL he_halted got %b%b exp 11", ld_halted, core_stall); end
    tick();
    core_req = 1'b0;
  endtask

  task automatic test_halt_load();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL hl_write got %b%b %h exp 11 00000100", ld_gnt, mem_we, mem_addr); end
    tick();
    ld_we = 1'b0;
    @(negedge clk);
    checks++; if (ld_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL hl_read got %b%b exp 10", ld_gnt, mem_we); end
    tick();
    ld_req = 1'b0; ld_halt = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
    @(negedge clk);
    checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hl_ld_rdata got %b %h exp 1 deadbeef", ld_rvalid, ld_rdata); end
    checks++; if (core_stall !== 1'b1 || ld_halted !== 1'b1) begin errors++; $display("FAIL hl_still_halted got %b%b exp 11", core_stall, ld_halted); end
    tick();
    @(negedge clk);
    checks++; if (core_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL hl_core_grant got %b%b %h exp 01 00000100", core_stall, mem_en, mem_addr); end
    checks++; if (ld_halted !== 1'b0 || ld_rvalid !== 1'b0) begin errors++; $display("FAIL hl_exit got %b%b exp 00", ld_halted, ld_rvalid); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hl_core_rdata got %b %h exp 1 deadbeef", core_rvalid, core_rdata); end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 6; i++) begin
      tick();
      idle();
      if (i % 2 == 0) begin
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
      end else begin
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'(i);
      end
      @(negedge clk);
      checks++; if (mem_en !== 1'b1 || core_stall !== 1'b0 || ld_gnt !== (i % 2 == 0)) begin
        errors++; $display("FAIL alt_grant cyc %0d got %b%b%b", i, mem_en, core_stall, ld_gnt); end
      checks++; if (ld_rvalid !== (i % 2 == 1) || core_rvalid !== 1'b0) begin
        errors++; $display("FAIL alt_rvalid cyc %0d got %b%b exp %b0", i, ld_rvalid, core_rvalid, (i % 2 == 1)); end
      if (i % 2 == 1) begin
        checks++; if (ld_rdata !== 32'h1234_5678) begin errors++; $display("FAIL alt_rdata cyc %0d got %h exp 12345678", i, ld_rdata); end
      end
      checks++; if (dut.wait_cnt !== '0) begin errors++; $display("FAIL alt_wait_cnt cyc %0d got %0d exp 0", i, dut.wait_cnt); end
    end
    tick();
    idle();
  endtask

  task automatic test_reset_inflight();
    tick();
    ld_halt = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (ld_halted !== 1'b1) begin errors++; $display("FAIL ri_halted got %b exp 1", ld_halted); end
    tick();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    @(posedge clk);
    #2;
    checks++; if (ld_rvalid !== 1'b1) begin errors++; $display("FAIL ri_pending got %b exp 1", ld_rvalid); end
    rst = 1'b0;
    ld_req = 1'b0;
    #1;
    checks++; if ({ld_rvalid, core_rvalid, ld_halted, mem_en} !== 4'b0000) begin
      errors++; $display("FAIL ri_async got %b exp 0000", {ld_rvalid, core_rvalid, ld_halted, mem_en}); end
    ld_halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    checks++; if (core_stall !== 1'b0 || mem_en !== 1'b1) begin errors++; $display("FAIL ri_regrant got %b%b exp 01", core_stall, mem_en); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ri_rdata got %b %h exp 1 12345678", core_rvalid, core_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h40 >> 2] = 32'h1234_5678;
    test_reset();
    test_core_read();
    test_contention();
    test_halt_entry();
    test_halt_load();
    test_alternate();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
